// File: rtl/vga_pkg.sv
// Shared definitions for the SVGA raster timing generator: default 800x600@60
// timing, the raster phase type, the sync-flag bundle, and the phase decoder
// used for both the horizontal and the vertical axis.
package vga_pkg;

    localparam int DEF_HACTIVE    = 800;
    localparam int DEF_HFP        = 40;
    localparam int DEF_HSYNC      = 128;
    localparam int DEF_HBP        = 88;
    localparam int DEF_VACTIVE    = 600;
    localparam int DEF_VFP        = 1;
    localparam int DEF_VSYNC      = 4;
    localparam int DEF_VBP        = 23;
    localparam int DEF_PIPE_DELAY = 1;

    typedef enum logic [1:0] {
        FRONT  = 2'd0,
        SYNC   = 2'd1,
        BACK   = 2'd2,
        ACTIVE = 2'd3
    } phase_t;

    // Flags that travel alongside a spot value through the colour pipeline.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } sync_flags_t;

    // Coordinates count up from -(fp+sync+bp) to active-1, so the blanking
    // phases are fixed negative windows ending at -1 and only sync and back
    // porch widths are needed to classify a coordinate.
    function automatic phase_t phase_of(input logic signed [10:0] c,
                                        input logic signed [10:0] sync_w,
                                        input logic signed [10:0] bp_w);
        phase_t ph;
        if (!c[10]) begin
            ph = ACTIVE;
        end else if (c < -(sync_w + bp_w)) begin
            ph = FRONT;
        end else if (c < -bp_w) begin
            ph = SYNC;
        end else begin
            ph = BACK;
        end
        return ph;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Shift register that delays the {hs, vs, act} flags by DEPTH clocks so they
// line up with colour returned by the pixel generators.
module sync_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  sync_flags_t flags_i,
    output sync_flags_t flags_o
);

    sync_flags_t stages_q [DEPTH];

    // Shift flags one stage per clock; reset clears every stage to inactive.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages_q[i] <= '0;
            end
        end else begin
            stages_q[0] <= flags_i;
            for (int i = 1; i < DEPTH; i++) begin
                stages_q[i] <= stages_q[i-1];
            end
        end
    end

    assign flags_o = stages_q[DEPTH-1];

endmodule

// File: rtl/vga_timing.sv
// SVGA raster timing generator and DAC output stage. Counts signed pixel
// coordinates whose negative values are blanking, hands them to the colour
// generators, and re-aligns the returned colour with delayed sync/blank flags.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   HACTIVE    = DEF_HACTIVE,
    parameter int   HFP        = DEF_HFP,
    parameter int   HSYNC      = DEF_HSYNC,
    parameter int   HBP        = DEF_HBP,
    parameter int   VACTIVE    = DEF_VACTIVE,
    parameter int   VFP        = DEF_VFP,
    parameter int   VSYNC      = DEF_VSYNC,
    parameter int   VBP        = DEF_VBP,
    parameter logic HS_POL     = 1'b1,
    parameter logic VS_POL     = 1'b1,
    parameter int   PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic signed [10:0] spotX,
    output logic signed [10:0] spotY,
    output logic               frame_start,
    input  logic [7:0]         in_r,
    input  logic [7:0]         in_g,
    input  logic [7:0]         in_b,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank
);

    localparam int H_BLANK = HFP + HSYNC + HBP;
    localparam int V_BLANK = VFP + VSYNC + VBP;

    // Every coordinate must fit the signed 11-bit counters.
    if (H_BLANK > 1024 || HACTIVE - 1 > 1023 || V_BLANK > 1024 || VACTIVE - 1 > 1023) begin : g_range_err
        $error("vga_timing: timing parameters exceed the signed 11-bit coordinate range");
    end
    if (PIPE_DELAY < 1) begin : g_delay_err
        $error("vga_timing: PIPE_DELAY must be at least 1");
    end

    localparam logic signed [10:0] H_MIN   = 11'(-H_BLANK);
    localparam logic signed [10:0] H_MAX   = 11'(HACTIVE - 1);
    localparam logic signed [10:0] V_MIN   = 11'(-V_BLANK);
    localparam logic signed [10:0] V_MAX   = 11'(VACTIVE - 1);
    localparam logic signed [10:0] HSYNC_W = 11'(HSYNC);
    localparam logic signed [10:0] HBP_W   = 11'(HBP);
    localparam logic signed [10:0] VSYNC_W = 11'(VSYNC);
    localparam logic signed [10:0] VBP_W   = 11'(VBP);

    logic signed [10:0] x_q, x_d;
    logic signed [10:0] y_q, y_d;
    logic               frame_start_q, frame_start_d;
    sync_flags_t        raw_q, raw_d;
    sync_flags_t        dly_flags;
    phase_t             h_phase_d, v_phase_d;

    logic               vga_hs_q, vga_vs_q, vga_blank_q;
    logic [7:0]         vga_r_q, vga_g_q, vga_b_q;

    // Next raster position, plus the flags describing that position so they
    // can be registered in the same clock as the coordinates.
    always_comb begin
        x_d = x_q + 11'sd1;
        y_d = y_q;
        if (x_q == H_MAX) begin
            x_d = H_MIN;
            y_d = (y_q == V_MAX) ? V_MIN : y_q + 11'sd1;
        end
        h_phase_d     = phase_of(x_d, HSYNC_W, HBP_W);
        v_phase_d     = phase_of(y_d, VSYNC_W, VBP_W);
        raw_d.hs      = (h_phase_d == SYNC);
        raw_d.vs      = (v_phase_d == SYNC);
        raw_d.act     = (h_phase_d == ACTIVE) && (v_phase_d == ACTIVE);
        frame_start_d = (x_d == 11'sd0) && (y_d == 11'sd0);
    end

    // Raster counters and the raw flags that are coincident with them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q           <= H_MIN;
            y_q           <= V_MIN;
            frame_start_q <= 1'b0;
            raw_q         <= '0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            raw_q         <= raw_d;
        end
    end

    sync_delay #(
        .DEPTH (PIPE_DELAY)
    ) u_sync_delay (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .flags_i (raw_q),
        .flags_o (dly_flags)
    );

    // Output register: syncs at their asserted polarity, colour forced to
    // black whenever the delayed spot lies outside the active area.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_hs_q    <= !HS_POL;
            vga_vs_q    <= !VS_POL;
            vga_blank_q <= 1'b1;
            vga_r_q     <= 8'h00;
            vga_g_q     <= 8'h00;
            vga_b_q     <= 8'h00;
        end else begin
            vga_hs_q    <= dly_flags.hs ? HS_POL : !HS_POL;
            vga_vs_q    <= dly_flags.vs ? VS_POL : !VS_POL;
            vga_blank_q <= !dly_flags.act;
            vga_r_q     <= dly_flags.act ? in_r : 8'h00;
            vga_g_q     <= dly_flags.act ? in_g : 8'h00;
            vga_b_q     <= dly_flags.act ? in_b : 8'h00;
        end
    end

    assign spotX       = x_q;
    assign spotY       = y_q;
    assign frame_start = frame_start_q;
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign vga_blank   = vga_blank_q;
    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default horizontal timing, a short frame (4 active
// lines, vertical blank 1+4+3 = 8 lines, frame = 12 lines = 12672 clocks) and
// PIPE_DELAY = 2. Outputs for the spot presented after edge n appear after
// edge n+3. Colour source: in_r = 255, in_b = 0xA5, in_g = spotX[7:0] two
// clocks late.
module tb_vga_timing;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic signed [10:0] spotX, spotY;
    logic               frame_start;
    logic [7:0]         in_r = 8'hFF;
    logic [7:0]         in_g = 8'h00;
    logic [7:0]         in_b = 8'hA5;
    logic [7:0]         vga_r, vga_g, vga_b;
    logic               vga_hs, vga_vs, vga_blank;

    vga_timing #(
        .VACTIVE    (4),
        .VBP        (3),
        .PIPE_DELAY (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spotX       (spotX),
        .spotY       (spotY),
        .frame_start (frame_start),
        .in_r        (in_r),
        .in_g        (in_g),
        .in_b        (in_b),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank   (vga_blank)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded 100000 clocks");
        $fatal(1, "watchdog");
    end

    // scoreboard counters
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // colour generator model: two-clock latency on spotX
    logic [7:0] g_h0 = 8'h00;
    logic [7:0] g_h1 = 8'h00;
    initial begin
        forever begin
            @(negedge clk);
            in_g = g_h1;
            g_h1 = g_h0;
            g_h0 = spotX[7:0];
        end
    end

    // run-length monitors
    logic mon_en = 1'b0;
    int   mon_cyc = 0;
    int   hs_run = 0, vs_run = 0, act_run = 0;
    int   hs_runs = 0, vs_runs = 0, act_runs = 0;
    int   gate_err = 0;
    int   last_x0 = -1;

    always @(negedge clk) begin
        if (mon_en) begin
            mon_cyc++;
            if (vga_hs) hs_run++;
            else if (hs_run != 0) begin
                check("hsync width", hs_run, 128);
                hs_runs++;
                hs_run = 0;
            end
            if (vga_vs) vs_run++;
            else if (vs_run != 0) begin
                check("vsync width", vs_run, 4 * 1056);
                vs_runs++;
                vs_run = 0;
            end
            if (!vga_blank) act_run++;
            else if (act_run != 0) begin
                check("active run", act_run, 800);
                act_runs++;
                act_run = 0;
            end
            if (vga_blank) begin
                if ((vga_r | vga_g | vga_b) != 8'h00) gate_err++;
            end else if (vga_r != 8'hFF || vga_b != 8'hA5) begin
                gate_err++;
            end
            if (spotX == 11'sd0) begin
                if (last_x0 >= 0) check("line period", mon_cyc - last_x0, 1056);
                last_x0 = mon_cyc;
            end
        end
    end

    // directed vectors: n = edges after reset release
    typedef struct {
        int                 n;
        logic signed [10:0] x;
        logic signed [10:0] y;
        logic               fs;
        logic               hs;
        logic               vs;
        logic               bl;
        logic [7:0]         r;
        logic [7:0]         g;
        logic [7:0]         b;
    } vec_t;

    function automatic vec_t mk(int n, int x, int y, bit fs, bit hs, bit vs, bit bl,
                                int r, int g, int b);
        vec_t v;
        v.n  = n;
        v.x  = 11'(x);
        v.y  = 11'(y);
        v.fs = fs;
        v.hs = hs;
        v.vs = vs;
        v.bl = bl;
        v.r  = 8'(r);
        v.g  = 8'(g);
        v.b  = 8'(b);
        return v;
    endfunction

    vec_t vecs[$];
    int   edges;
    int   k;
    int   first_hs;
    bit   found;

    initial begin
        //            n      x     y  fs hs vs bl  r    g   b
        vecs.push_back(mk(0,     -256, -8, 0, 0, 0, 1, 0,   0,  0));
        vecs.push_back(mk(1,     -255, -8, 0, 0, 0, 1, 0,   0,  0));
        vecs.push_back(mk(42,    -214, -8, 0, 0, 0, 1, 0,   0,  0));
        vecs.push_back(mk(43,    -213, -8, 0, 1, 0, 1, 0,   0,  0));
        vecs.push_back(mk(170,   -86,  -8, 0, 1, 0, 1, 0,   0,  0));
        vecs.push_back(mk(171,   -85,  -8, 0, 0, 0, 1, 0,   0,  0));
        vecs.push_back(mk(1058,  -254, -7, 0, 0, 0, 1, 0,   0,  0));
        vecs.push_back(mk(1059,  -253, -7, 0, 0, 1, 1, 0,   0,  0));
        vecs.push_back(mk(5282,  -254, -3, 0, 0, 1, 1, 0,   0,  0));
        vecs.push_back(mk(5283,  -253, -3, 0, 0, 0, 1, 0,   0,  0));
        vecs.push_back(mk(8703,  -1,    0, 0, 0, 0, 1, 0,   0,  0));
        vecs.push_back(mk(8704,   0,    0, 1, 0, 0, 1, 0,   0,  0));
        vecs.push_back(mk(8706,   2,    0, 0, 0, 0, 1, 0,   0,  0));
        vecs.push_back(mk(8707,   3,    0, 0, 0, 0, 0, 255, 0,  165));
        vecs.push_back(mk(9506,  -254,  1, 0, 0, 0, 0, 255, 31, 165));
        vecs.push_back(mk(9507,  -253,  1, 0, 0, 0, 1, 0,   0,  0));
        vecs.push_back(mk(11119,  303,  2, 0, 0, 0, 0, 255, 44, 165));
        vecs.push_back(mk(12674, -254, -8, 0, 0, 0, 0, 255, 31, 165));
        vecs.push_back(mk(12675, -253, -8, 0, 0, 0, 1, 0,   0,  0));
        vecs.push_back(mk(13731, -253, -7, 0, 0, 1, 1, 0,   0,  0));
        vecs.push_back(mk(21375, -1,    0, 0, 0, 0, 1, 0,   0,  0));
        vecs.push_back(mk(21376,  0,    0, 1, 0, 0, 1, 0,   0,  0));

        // reset held: values while in reset
        repeat (3) @(negedge clk);
        check("reset spotX", spotX, -256);
        check("reset spotY", spotY, -8);
        check("reset frame_start", frame_start, 0);
        check("reset blank", vga_blank, 1);
        check("reset hs", vga_hs, 0);
        check("reset vs", vga_vs, 0);
        check("reset rgb", {vga_r, vga_g, vga_b}, 0);

        // release and walk the vector table
        reset_n = 1'b1;
        mon_en  = 1'b1;
        edges   = 0;
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            while (edges < vecs[i].n) begin
                @(posedge clk);
                edges++;
                if (edges == vecs[i].n) @(negedge clk);
            end
            check($sformatf("row%0d n=%0d spotX", i, vecs[i].n), spotX, vecs[i].x);
            check($sformatf("row%0d n=%0d spotY", i, vecs[i].n), spotY, vecs[i].y);
            check($sformatf("row%0d n=%0d frame_start", i, vecs[i].n), frame_start, vecs[i].fs);
            check($sformatf("row%0d n=%0d hs", i, vecs[i].n), vga_hs, vecs[i].hs);
            check($sformatf("row%0d n=%0d vs", i, vecs[i].n), vga_vs, vecs[i].vs);
            check($sformatf("row%0d n=%0d blank", i, vecs[i].n), vga_blank, vecs[i].bl);
            check($sformatf("row%0d n=%0d r", i, vecs[i].n), vga_r, vecs[i].r);
            check($sformatf("row%0d n=%0d g", i, vecs[i].n), vga_g, vecs[i].g);
            check($sformatf("row%0d n=%0d b", i, vecs[i].n), vga_b, vecs[i].b);
        end

        // run-length totals over the first frame and a half
        check("hsync pulses", hs_runs, 21);
        check("vsync pulses", vs_runs, 2);
        check("active lines", act_runs, 4);
        check("blank gating errors", gate_err, 0);

        // mid-frame reset at spot (400, 2)
        found = 1'b0;
        for (int j = 0; j < 20000; j++) begin
            if (spotX == 11'sd400 && spotY == 11'sd2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach spot (400,2)", found, 1);
        check("pre-reset blank", vga_blank, 0);
        mon_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset spotX", spotX, -256);
        check("async reset spotY", spotY, -8);
        check("async reset blank", vga_blank, 1);
        check("async reset hs/vs", {vga_hs, vga_vs}, 0);
        check("async reset rgb", {vga_r, vga_g, vga_b}, 0);
        repeat (3) @(negedge clk);
        check("held reset spotX", spotX, -256);
        check("held reset frame_start", frame_start, 0);

        // release and time the restart
        reset_n  = 1'b1;
        k        = 0;
        first_hs = -1;
        while (!frame_start && k < 20000) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (vga_hs && first_hs < 0) first_hs = k;
        end
        check("restart frame_start delay", k, 28 * 1056 - 20 * 1056 + 256);
        check("restart first hsync", first_hs, 43);
        check("restart spot origin", {spotX, spotY}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
